// File: rtl/micro_pkg.sv
// Shared types and constants for the microwave power timer: FSM states, BCD digits, 7-seg table.
// The power cap applies only to builds with MICRO_POWER_LEVEL_EN.
package micro_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    COOK  = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int MAX_POWER = 10;

  // Active-high segments a..g on bits 0..6.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

endpackage

// File: rtl/bcd7seg.sv
// One BCD digit to 7-segment decode, purely combinational; codes above 9 blank the digit.
module bcd7seg
  import micro_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b0000000;
    if (bcd <= 4'd9) seg = SEG_TABLE[bcd];
  end

endmodule

// File: rtl/micro_power_timer.sv
// Microwave countdown timer: keypad BCD entry, start/stop/clear FSM, per-second countdown, 7-seg out.
// Optional duty-cycle power control when MICRO_POWER_LEVEL_EN is defined (adds the power port).
module micro_power_timer #(
  parameter int TICK_DIV   = 100,
  parameter int MIN_DIGITS = 2,
  parameter int DONE_SECS  = 3
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [9:0]                  teclado,
  input  logic                        comecan,
  input  logic                        paren,
  input  logic                        limpan,
  input  logic                        portafechada,
  output logic                        m_on,
  output logic                        done,
  output logic [2:0]                  state_o,
  output logic [7*(2+MIN_DIGITS)-1:0] seg
`ifdef MICRO_POWER_LEVEL_EN
  ,
  input  logic [3:0]                  power
`endif
);
  import micro_pkg::*;

  localparam int ND = 2 + MIN_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DONE_SECS + 1);

  state_t            state, state_n;
  bcd_t [ND-1:0]     dig, dig_n, dig_dec;
  logic [PW-1:0]     presc, presc_n;
  logic [DW-1:0]     dsec, dsec_n;
  logic              start_q, stop_q, clr_q;
  logic [9:0]        key_q;
  logic              start_e, stop_e, clr_e, key_ok, tick, time_nz;
  logic [3:0]        key_val;
  logic              borrow, cook_entry, m_on_n;

  assign start_e = start_q & ~comecan;
  assign stop_e  = stop_q & ~paren;
  assign clr_e   = clr_q & ~limpan;
  assign key_ok  = (key_q == '0) && $onehot(teclado);
  assign tick    = (presc == PW'(TICK_DIV - 1));
  assign time_nz = |dig;
  assign done    = (state == DONE);
  assign state_o = state;

  always_comb begin
    key_val = 4'd0;
    for (int k = 0; k < 10; k++)
      if (teclado[k]) key_val = 4'(k);
  end

  // Ripple BCD borrow; seconds tens reloads to 5, every other digit to 9.
  always_comb begin
    dig_dec = dig;
    borrow  = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (borrow) begin
        if (dig[i] != 4'd0) begin
          dig_dec[i] = dig[i] - 4'd1;
          borrow     = 1'b0;
        end else begin
          dig_dec[i] = (i == 1) ? 4'd5 : 4'd9;
        end
      end
    end
  end

  always_comb begin
    state_n    = state;
    dig_n      = dig;
    presc_n    = presc;
    dsec_n     = dsec;
    cook_entry = 1'b0;
    if (clr_e) begin
      state_n = IDLE;
      dig_n   = '0;
      presc_n = '0;
      dsec_n  = '0;
    end else begin
      case (state)
        IDLE, ENTRY: begin
          if (stop_e) begin
            state_n = IDLE;
            dig_n   = '0;
          end else if (start_e && state == ENTRY && portafechada && time_nz) begin
            state_n    = COOK;
            presc_n    = '0;
            cook_entry = 1'b1;
          end else if (key_ok) begin
            state_n = ENTRY;
            dig_n   = {dig[ND-2:0], key_val};
          end
        end
        COOK: begin
          if (stop_e || !portafechada) begin
            state_n = PAUSE;
          end else if (tick) begin
            presc_n = '0;
            if (dig_dec == '0) begin
              state_n = DONE;
              dig_n   = '0;
              dsec_n  = '0;
            end else begin
              dig_n = dig_dec;
            end
          end else begin
            presc_n = presc + 1'b1;
          end
        end
        PAUSE: begin
          if (stop_e) begin
            state_n = IDLE;
            dig_n   = '0;
          end else if (start_e && portafechada && time_nz) begin
            state_n    = COOK;
            presc_n    = '0;
            cook_entry = 1'b1;
          end
        end
        DONE: begin
          if (stop_e) begin
            state_n = IDLE;
            dig_n   = '0;
          end else if (tick) begin
            presc_n = '0;
            if (dsec == DW'(DONE_SECS - 1)) state_n = IDLE;
            else dsec_n = dsec + 1'b1;
          end else begin
            presc_n = presc + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          dig_n   = '0;
        end
      endcase
    end
  end

`ifdef MICRO_POWER_LEVEL_EN
  logic [3:0] slot, slot_n, pwr;

  always_comb begin
    pwr = power;
    if (power == 4'd0) pwr = 4'd1;
    else if (power > 4'(MAX_POWER)) pwr = 4'(MAX_POWER);
  end

  always_comb begin
    slot_n = slot;
    if (cook_entry) slot_n = 4'd0;
    else if (state == COOK && state_n == COOK && tick)
      slot_n = (slot == 4'(MAX_POWER - 1)) ? 4'd0 : slot + 4'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) slot <= 4'd0;
    else         slot <= slot_n;
  end

  assign m_on_n = (state_n == COOK) && portafechada && (slot_n < pwr);
`else
  assign m_on_n = (state_n == COOK) && portafechada;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      dig     <= '0;
      presc   <= '0;
      dsec    <= '0;
      start_q <= 1'b1;
      stop_q  <= 1'b1;
      clr_q   <= 1'b1;
      key_q   <= '0;
      m_on    <= 1'b0;
    end else begin
      state   <= state_n;
      dig     <= dig_n;
      presc   <= presc_n;
      dsec    <= dsec_n;
      start_q <= comecan;
      stop_q  <= paren;
      clr_q   <= limpan;
      key_q   <= teclado;
      m_on    <= m_on_n;
    end
  end

  for (genvar g = 0; g < ND; g++) begin : g_seg
    bcd7seg u_seg (
      .bcd (dig[g]),
      .seg (seg[7*g +: 7])
    );
  end

endmodule

// File: doc/micro_power_timer.md
MICRO_POWER_TIMER -- requirements
Module: micro_power_timer

Interface
REQ-001 Parameter TICK_DIV, default 100: clk cycles per countdown second, >=2.
REQ-002 Parameter MIN_DIGITS, default 2: BCD minute digits (1..2); total digits ND = 2+MIN_DIGITS.
REQ-003 Parameter DONE_SECS, default 3: seconds `done` stays high after countdown expiry.
REQ-004 Ports: clk in 1, rising-edge clock; resetn in 1, asynchronous active-low reset.
REQ-005 teclado in 10: one-hot keypad, bit k = digit k, all-zero = no key.
REQ-006 comecan, paren, limpan in 1 each: start/stop/clear buttons, active-low levels.
REQ-007 portafechada in 1: door closed = 1.
REQ-008 power in 4: power level 1..10 (present only with MICRO_POWER_LEVEL_EN).
REQ-009 m_on out 1: magnetron enable; done out 1: cycle-complete flag; state_o out 3: FSM state.
REQ-010 seg out 7*ND: per-digit 7-segment codes, digit 0 (seconds ones) in bits [6:0], active-high segments a..g = bits 0..6.

Function
REQ-011 States: IDLE, ENTRY, COOK, PAUSE, DONE; each button acts only on its falling edge (registered previous value).
REQ-012 Key accepted on the cycle teclado goes from 0 to exactly one bit set; non-one-hot or held values ignored.
REQ-013 Accepted key in IDLE/ENTRY shifts BCD digits left one place, new digit into seconds ones, top digit discarded; state -> ENTRY.
REQ-014 Keys ignored in COOK, PAUSE, DONE.
REQ-015 Start edge in ENTRY or PAUSE with portafechada=1 and time nonzero -> COOK, second prescaler cleared; otherwise ignored.
REQ-016 COOK: one decrement per TICK_DIV cycles; first decrement TICK_DIV cycles after COOK entry.
REQ-017 Decrement: ones>0 -> ones-1; else tens>0 -> tens-1, ones=9; else borrow from minutes (BCD, ripple), tens=5, ones=9; entered tens 6..9 count down unmodified.
REQ-018 Decrement reaching all-zero -> DONE same cycle; m_on low that cycle.
REQ-019 Door open in COOK -> PAUSE next cycle, time held; start edge with door closed resumes.
REQ-020 Stop edge in COOK -> PAUSE; stop edge in PAUSE, ENTRY, DONE -> IDLE, time cleared.
REQ-021 Clear edge in any state -> IDLE, time zero, done low; clear wins over simultaneous start/stop/key.
REQ-022 Simultaneous start and stop edges: stop wins.
REQ-023 DONE: done=1, m_on=0 for DONE_SECS seconds, then IDLE; start edge in DONE ignored.
REQ-024 m_on registered: 1 only in COOK with portafechada=1 (subject to REQ-029).
REQ-025 seg is combinational decode of current BCD digits; invalid BCD (>9) shows all segments off.

Reset
REQ-026 resetn low: state IDLE, all digits 0, prescaler 0, edge registers 1 (buttons released), teclado history 0, slot counter 0.
REQ-027 During reset m_on=0, done=0, state_o=IDLE, seg shows all-zero digits (7'b0111111 each).
REQ-028 Reset asserted mid-COOK drops m_on asynchronously, no cycle delay.

Configuration
REQ-029 MICRO_POWER_LEVEL_EN defined: 10-second slot counter 0..9 advances per second in COOK; m_on=1 only while slot < power; power 0 treated as 1, >10 as 10; slot cleared on COOK entry.
REQ-030 MICRO_POWER_LEVEL_EN undefined: power port absent, no slot counter, m_on per REQ-024 (full power).

Structure
REQ-031 Shared package micro_pkg: state enum, 7-seg constant table, BCD digit typedef, MAX_POWER=10.
REQ-032 One sub-module bcd7seg (4-bit BCD -> 7 seg), instantiated ND times; FSM, counters, digit register in top.

Verification (TICK_DIV=4, MIN_DIGITS=2, DONE_SECS=3)
REQ-033 Keys 1,0,5 then start, door closed -> digits 0105 (1:05), COOK, m_on=1; after 4 cycles 0104; 0100 -> 0059.
REQ-034 Time 0002, start, door opens after 5 cycles -> PAUSE, m_on=0, digits 0001 held; close+start resumes; expiry -> done=1 for 12 cycles, then IDLE.
REQ-035 Start with time 0000 or door open -> state stays ENTRY/IDLE, m_on=0.
REQ-036 Stop in COOK -> PAUSE; second stop -> IDLE, digits 0000; clear+start same cycle -> IDLE.
REQ-037 teclado=10'b0000000011, or key held 20 cycles -> at most one digit entered (none for non-one-hot).
REQ-038 MICRO_POWER_LEVEL_EN, power=3, time 0020 -> m_on high 3 of every 10 seconds; resetn low mid-COOK -> m_on=0 immediately.
